fpu_issue_ctrl: RTL and testbench

//  Sequential issue/writeback controller for the RV32F FPU. Decodes funct7/funct3 into an FPU op, issues it to
//  the multi-cycle datapath and holds the controls until writeback. Per-op latencies are parameters.

---
 rtl/fpu_issue_ctrl_pkg.sv | 50 +++++
 rtl/fpu_issue_ctrl_if.sv | 37 +++
 rtl/fpu_issue_ctrl_op_decode.sv | 59 +++++
 rtl/fpu_issue_ctrl.sv | 110 +++++++++++
 tb/tb_fpu_issue_ctrl.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/fpu_issue_ctrl_pkg.sv
// Shared encodings and decode types for the FPU issue/writeback controller.
package fpu_issue_ctrl_pkg;

    // Width of the latency field carried in the decode result.
    localparam int DEC_LAT_W = 4;

    typedef enum logic [3:0] {
        OP_ADD    = 4'b0000,
        OP_F2I    = 4'b0001,
        OP_I2F    = 4'b0010,
        OP_MUL    = 4'b0011,
        OP_CMP    = 4'b0100,
        OP_MINMAX = 4'b0101,
        OP_CLASS  = 4'b0110,
        OP_NONE   = 4'b1111
    } fpu_op_e;

    localparam logic [6:0] F7_ADD    = 7'b0000000;
    localparam logic [6:0] F7_SUB    = 7'b0000100;
    localparam logic [6:0] F7_MUL    = 7'b0001000;
    localparam logic [6:0] F7_F2I    = 7'b1100000;
    localparam logic [6:0] F7_I2F    = 7'b1101000;
    localparam logic [6:0] F7_CMP    = 7'b1010000;
    localparam logic [6:0] F7_MINMAX = 7'b0010100;
    localparam logic [6:0] F7_CLS_MV = 7'b1110000;
    localparam logic [6:0] F7_MVWX   = 7'b1111000;

    localparam logic [2:0] F3_MVXW  = 3'b000;
    localparam logic [2:0] F3_CLASS = 3'b001;

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_WB} state_e;

    // Controls that are held for the life of an in-flight op.
    typedef struct packed {
        fpu_op_e op;
        logic    wb_freg;
        logic    wb_ireg;
        logic    wb_ffr;
        logic    mov_freg;
        logic    mov_ireg;
        logic    mov_i2f;
    } ctl_t;

    typedef struct packed {
        ctl_t                 ctl;
        logic [DEC_LAT_W-1:0] lat;
        logic                 legal;
    } decode_t;

endpackage

// File: rtl/fpu_issue_ctrl_if.sv
// ID-stage / datapath facing signals of the FPU issue controller.
interface fpu_issue_ctrl_if #(parameter int REG_AW = 5);
    logic              flush;
    logic              instr_valid;
    logic              instr_ready;
    logic [6:0]        funct7;
    logic [2:0]        funct3;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [REG_AW-1:0] rd;
    logic              issue_start;
    logic [3:0]        fpu_op;
    logic              mov_from_freg;
    logic              mov_from_ireg;
    logic              mov_int_to_fpu;
    logic              wb_valid;
    logic              wb_freg;
    logic              wb_ireg;
    logic              wb_from_float_result;
    logic [REG_AW-1:0] wb_rd;
    logic              busy;
    logic              illegal;

    modport master (
        output flush, instr_valid, funct7, funct3, rs1, rs2, rd,
        input  instr_ready, issue_start, fpu_op, mov_from_freg, mov_from_ireg,
               mov_int_to_fpu, wb_valid, wb_freg, wb_ireg, wb_from_float_result,
               wb_rd, busy, illegal
    );

    modport slave (
        input  flush, instr_valid, funct7, funct3, rs1, rs2, rd,
        output instr_ready, issue_start, fpu_op, mov_from_freg, mov_from_ireg,
               mov_int_to_fpu, wb_valid, wb_freg, wb_ireg, wb_from_float_result,
               wb_rd, busy, illegal
    );
endinterface

// File: rtl/fpu_issue_ctrl_op_decode.sv
// Combinational funct7/funct3 decode into FPU op controls and latency.
module fpu_op_decode
    import fpu_issue_ctrl_pkg::*;
#(
    parameter int ADD_LAT = 3,
    parameter int MUL_LAT = 4,
    parameter int CVT_LAT = 2,
    parameter int CMP_LAT = 1
) (
    input  logic [6:0] funct7,
    input  logic [2:0] funct3,
    output decode_t    dec
);
    localparam logic [DEC_LAT_W-1:0] L_ADD = DEC_LAT_W'(ADD_LAT);
    localparam logic [DEC_LAT_W-1:0] L_MUL = DEC_LAT_W'(MUL_LAT);
    localparam logic [DEC_LAT_W-1:0] L_CVT = DEC_LAT_W'(CVT_LAT);
    localparam logic [DEC_LAT_W-1:0] L_CMP = DEC_LAT_W'(CMP_LAT);

    // Table decode; anything unlisted clears legal.
    always_comb begin
        dec        = '0;
        dec.ctl.op = OP_NONE;
        dec.legal  = 1'b1;
        case (funct7)
            F7_ADD, F7_SUB: begin
                dec.ctl.op = OP_ADD;    dec.ctl.wb_freg = 1'b1; dec.lat = L_ADD;
            end
            F7_MUL: begin
                dec.ctl.op = OP_MUL;    dec.ctl.wb_freg = 1'b1; dec.lat = L_MUL;
            end
            F7_F2I: begin
                dec.ctl.op = OP_F2I;    dec.ctl.wb_ireg = 1'b1; dec.ctl.wb_ffr = 1'b1; dec.lat = L_CVT;
            end
            F7_I2F: begin
                dec.ctl.op = OP_I2F;    dec.ctl.wb_freg = 1'b1; dec.ctl.mov_i2f = 1'b1; dec.lat = L_CVT;
            end
            F7_CMP: begin
                dec.ctl.op = OP_CMP;    dec.ctl.wb_ireg = 1'b1; dec.ctl.wb_ffr = 1'b1; dec.lat = L_CMP;
            end
            F7_MINMAX: begin
                dec.ctl.op = OP_MINMAX; dec.ctl.wb_freg = 1'b1; dec.lat = L_CMP;
            end
            F7_CLS_MV: begin
                dec.lat = L_CMP;
                if (funct3 == F3_CLASS) begin
                    dec.ctl.op = OP_CLASS; dec.ctl.wb_ireg = 1'b1; dec.ctl.wb_ffr = 1'b1;
                end else if (funct3 == F3_MVXW) begin
                    dec.ctl.wb_ireg = 1'b1; dec.ctl.mov_freg = 1'b1;
                end else begin
                    dec.legal = 1'b0;
                end
            end
            F7_MVWX: begin
                dec.ctl.wb_freg = 1'b1; dec.ctl.mov_ireg = 1'b1; dec.lat = L_CMP;
            end
            default: dec.legal = 1'b0;
        endcase
    end
endmodule

// File: rtl/fpu_issue_ctrl.sv
// FPU issue/writeback controller: IDLE/EXEC/WB FSM, latency counter,
// hazard check against the op in writeback, and held datapath controls.
module fpu_issue_ctrl
    import fpu_issue_ctrl_pkg::*;
#(
    parameter int ADD_LAT = 3,
    parameter int MUL_LAT = 4,
    parameter int CVT_LAT = 2,
    parameter int CMP_LAT = 1,
    parameter int REG_AW  = 5,
    parameter int LAT_W   = 4
) (
    input  logic             clk,
    input  logic             rst,
    fpu_issue_ctrl_if.slave  bus
);
    state_e            state, state_nx;
    logic [LAT_W-1:0]  cnt, cnt_nx;
    ctl_t              ctl_q, ctl_nx;
    logic [REG_AW-1:0] rd_q, rd_nx;
    logic              issue_q, issue_nx;
    logic              ill_q, ill_nx;
    decode_t           dec;
    logic              in_wb, hazard, accept;

    fpu_op_decode #(
        .ADD_LAT(ADD_LAT), .MUL_LAT(MUL_LAT), .CVT_LAT(CVT_LAT), .CMP_LAT(CMP_LAT)
    ) u_dec (
        .funct7 (bus.funct7),
        .funct3 (bus.funct3),
        .dec    (dec)
    );

    // A new op may only depend on the retiring one once its result is out;
    // writes to integer x0 never create a dependency.
    assign in_wb  = (state == S_WB);
    assign hazard = in_wb && ((bus.rs1 == rd_q) || (bus.rs2 == rd_q) || (bus.rd == rd_q))
                    && !(ctl_q.wb_ireg && (rd_q == '0));
    assign bus.instr_ready = ((state == S_IDLE) || in_wb) && !hazard && !bus.flush && !rst;
    assign accept = bus.instr_valid && bus.instr_ready;

    // Next-state: flush wins, then accept (which also covers back-to-back in WB), then sequencing.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        ctl_nx   = ctl_q;
        rd_nx    = rd_q;
        issue_nx = 1'b0;
        ill_nx   = 1'b0;
        if (bus.flush) begin
            state_nx = S_IDLE;
        end else if (accept) begin
            if (dec.legal) begin
                ctl_nx   = dec.ctl;
                rd_nx    = bus.rd;
                issue_nx = 1'b1;
                if (dec.lat == DEC_LAT_W'(1)) begin
                    state_nx = S_WB;
                end else begin
                    state_nx = S_EXEC;
                    cnt_nx   = LAT_W'(dec.lat - DEC_LAT_W'(2));
                end
            end else begin
                ill_nx   = 1'b1;
                state_nx = S_IDLE;
            end
        end else begin
            case (state)
                S_EXEC: begin
                    if (cnt == '0) state_nx = S_WB;
                    else           cnt_nx   = cnt - LAT_W'(1);
                end
                S_WB:    state_nx = S_IDLE;
                default: state_nx = S_IDLE;
            endcase
        end
    end

    // State, counter and captured controls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            cnt     <= '0;
            ctl_q   <= '0;
            rd_q    <= '0;
            issue_q <= 1'b0;
            ill_q   <= 1'b0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            ctl_q   <= ctl_nx;
            rd_q    <= rd_nx;
            issue_q <= issue_nx;
            ill_q   <= ill_nx;
        end
    end

    assign bus.busy                 = (state != S_IDLE);
    assign bus.issue_start          = issue_q;
    assign bus.illegal              = ill_q;
    assign bus.fpu_op               = bus.busy ? ctl_q.op : OP_NONE;
    assign bus.mov_from_freg        = bus.busy && ctl_q.mov_freg;
    assign bus.mov_from_ireg        = bus.busy && ctl_q.mov_ireg;
    assign bus.mov_int_to_fpu       = bus.busy && ctl_q.mov_i2f;
    assign bus.wb_valid             = in_wb;
    assign bus.wb_freg              = in_wb && ctl_q.wb_freg;
    assign bus.wb_ireg              = in_wb && ctl_q.wb_ireg;
    assign bus.wb_from_float_result = in_wb && ctl_q.wb_ffr;
    assign bus.wb_rd                = in_wb ? rd_q : '0;
endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Self-checking bench for fpu_issue_ctrl: decode table, hand-written corner
// sequences and a randomized run against a timeline-based reference model.
module tb_fpu_issue_ctrl;
    localparam int AW = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fpu_issue_ctrl_if #(.REG_AW(AW)) bus ();

    fpu_issue_ctrl #(
        .ADD_LAT(3), .MUL_LAT(4), .CVT_LAT(2), .CMP_LAT(1), .REG_AW(AW), .LAT_W(4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference decode taken straight from the instruction table.
    typedef struct {
        bit legal; int op; bit freg; bit ireg; bit ffr; bit mvf; bit mvi; bit i2f; int lat;
    } ref_t;

    function automatic ref_t ref_dec(input logic [6:0] f7, input logic [2:0] f3);
        ref_t r = '{1'b1, 15, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1};
        case (f7)
            7'b0000000, 7'b0000100: begin r.op = 0; r.freg = 1; r.lat = 3; end
            7'b0001000: begin r.op = 3; r.freg = 1; r.lat = 4; end
            7'b1100000: begin r.op = 1; r.ireg = 1; r.ffr = 1; r.lat = 2; end
            7'b1101000: begin r.op = 2; r.freg = 1; r.i2f = 1; r.lat = 2; end
            7'b1010000: begin r.op = 4; r.ireg = 1; r.ffr = 1; end
            7'b0010100: begin r.op = 5; r.freg = 1; end
            7'b1111000: begin r.freg = 1; r.mvi = 1; end
            7'b1110000: begin
                if (f3 == 3'b001)      begin r.op = 6; r.ireg = 1; r.ffr = 1; end
                else if (f3 == 3'b000) begin r.ireg = 1; r.mvf = 1; end
                else                   r.legal = 0;
            end
            default: r.legal = 0;
        endcase
        return r;
    endfunction

    // Model: at most one op in flight, described by its accept cycle and latency.
    int   cyc = 0;
    bit   m_in = 0;
    int   m_acc = 0;
    ref_t m_d;
    int   m_rd = 0;
    int   m_ill_at = -1;

    // One clock cycle: drive inputs, compare every output with the model, advance the model.
    task automatic step(input bit v, input logic [6:0] f7, input logic [2:0] f3,
                        input int rs1, input int rs2, input int rd, input bit fl);
        bit live, wbv, haz, rdy;
        ref_t d;
        @(negedge clk);
        bus.instr_valid = v;  bus.funct7 = f7;  bus.funct3 = f3;
        bus.rs1 = AW'(rs1);   bus.rs2 = AW'(rs2); bus.rd = AW'(rd);
        bus.flush = fl;
        #1;
        live = m_in && (cyc > m_acc) && (cyc <= m_acc + m_d.lat);
        wbv  = live && (cyc == m_acc + m_d.lat);
        haz  = wbv && (rs1 == m_rd || rs2 == m_rd || rd == m_rd) && !(m_d.ireg && m_rd == 0);
        rdy  = (!live || wbv) && !haz && !fl;
        check("busy",        bus.busy,        live);
        check("issue_start", bus.issue_start, live && cyc == m_acc + 1);
        check("wb_valid",    bus.wb_valid,    wbv);
        check("illegal",     bus.illegal,     cyc == m_ill_at);
        check("instr_ready", bus.instr_ready, rdy);
        check("fpu_op",      bus.fpu_op,      live ? m_d.op : 15);
        check("mov_from_freg",  bus.mov_from_freg,  live && m_d.mvf);
        check("mov_from_ireg",  bus.mov_from_ireg,  live && m_d.mvi);
        check("mov_int_to_fpu", bus.mov_int_to_fpu, live && m_d.i2f);
        if (wbv) begin
            check("wb_freg", bus.wb_freg, m_d.freg);
            check("wb_ireg", bus.wb_ireg, m_d.ireg);
            check("wb_ffr",  bus.wb_from_float_result, m_d.ffr);
            check("wb_rd",   bus.wb_rd,   m_rd);
        end
        if (fl) m_in = 0;
        else if (v && rdy) begin
            d = ref_dec(f7, f3);
            if (d.legal) begin m_in = 1; m_acc = cyc; m_d = d; m_rd = rd; end
            else begin m_in = 0; m_ill_at = cyc + 1; end
        end
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 7'd0, 3'd0, 0, 0, 0, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"},     bus.busy,        0);
        check({tag, "_issue"},    bus.issue_start, 0);
        check({tag, "_wb_valid"}, bus.wb_valid,    0);
        check({tag, "_wb_freg"},  bus.wb_freg,     0);
        check({tag, "_wb_ireg"},  bus.wb_ireg,     0);
        check({tag, "_wb_rd"},    bus.wb_rd,       0);
        check({tag, "_illegal"},  bus.illegal,     0);
        check({tag, "_ready"},    bus.instr_ready, 0);
        check({tag, "_mov"},      {bus.mov_from_freg, bus.mov_from_ireg, bus.mov_int_to_fpu}, 0);
        check({tag, "_fpu_op"},   bus.fpu_op,      4'b1111);
    endtask

    typedef struct {
        logic [6:0] f7; logic [2:0] f3; int rd;
        int op; bit freg; bit ireg; bit ffr; bit mvf; bit mvi; bit i2f; int lat; bit legal;
    } vec_t;

    vec_t tab[12];
    logic [6:0] f7s [0:9];

    initial begin
        int iss_k, wb_k, ill_k, acc_k, busy_n, wbn, op_at_iss;
        bit w_freg, w_ireg, w_ffr, m_f, m_i, m_c, done;
        int w_rd;

        tab[0]  = '{7'b0000000, 3'd0, 3,  0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3, 1'b1};
        tab[1]  = '{7'b0000100, 3'd0, 7,  0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3, 1'b1};
        tab[2]  = '{7'b0001000, 3'd0, 9,  3,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4, 1'b1};
        tab[3]  = '{7'b1100000, 3'd1, 4,  1,  1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2, 1'b1};
        tab[4]  = '{7'b1101000, 3'd0, 6,  2,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2, 1'b1};
        tab[5]  = '{7'b1010000, 3'd2, 1,  4,  1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1, 1'b1};
        tab[6]  = '{7'b0010100, 3'd0, 2,  5,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1, 1'b1};
        tab[7]  = '{7'b1110000, 3'd1, 8,  6,  1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1, 1'b1};
        tab[8]  = '{7'b1110000, 3'd0, 10, 15, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1, 1'b1};
        tab[9]  = '{7'b1111000, 3'd0, 11, 15, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1, 1'b1};
        tab[10] = '{7'b0110011, 3'd0, 12, 15, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0};
        tab[11] = '{7'b1110000, 3'd2, 13, 15, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0};
        f7s = '{7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000, 7'b1101000,
                7'b1010000, 7'b0010100, 7'b1110000, 7'b1111000, 7'b0110011};

        bus.instr_valid = 0; bus.flush = 0; bus.funct7 = 0; bus.funct3 = 0;
        bus.rs1 = 0; bus.rs2 = 0; bus.rd = 0;
        #3;
        check_reset_outputs("reset");
        @(negedge clk);
        rst = 0;
        idle(2);

        // Decode table: one op alone, then watch when and what comes out.
        foreach (tab[n]) begin
            step(1, tab[n].f7, tab[n].f3, 20, 21, tab[n].rd, 0);
            iss_k = 0; wb_k = 0; ill_k = 0; busy_n = 0; op_at_iss = -1;
            w_freg = 0; w_ireg = 0; w_ffr = 0; w_rd = -1; m_f = 0; m_i = 0; m_c = 0;
            for (int k = 1; k <= 7; k++) begin
                idle(1);
                if (bus.busy) busy_n++;
                if (bus.illegal) ill_k = k;
                if (bus.issue_start) begin
                    iss_k = k; op_at_iss = bus.fpu_op;
                    m_f = bus.mov_from_freg; m_i = bus.mov_from_ireg; m_c = bus.mov_int_to_fpu;
                end
                if (bus.wb_valid) begin
                    wb_k = k; w_freg = bus.wb_freg; w_ireg = bus.wb_ireg;
                    w_ffr = bus.wb_from_float_result; w_rd = bus.wb_rd;
                end
            end
            check($sformatf("tab%0d_issue_cycle", n), iss_k, tab[n].legal ? 1 : 0);
            check($sformatf("tab%0d_wb_cycle", n),    wb_k,  tab[n].lat);
            check($sformatf("tab%0d_illegal", n),     ill_k, tab[n].legal ? 0 : 1);
            check($sformatf("tab%0d_busy_cycles", n), busy_n, tab[n].lat);
            if (tab[n].legal) begin
                check($sformatf("tab%0d_op", n),   op_at_iss, tab[n].op);
                check($sformatf("tab%0d_mov", n),  {m_f, m_i, m_c}, {tab[n].mvf, tab[n].mvi, tab[n].i2f});
                check($sformatf("tab%0d_wbsel", n), {w_freg, w_ireg, w_ffr}, {tab[n].freg, tab[n].ireg, tab[n].ffr});
                check($sformatf("tab%0d_wb_rd", n), w_rd, tab[n].rd);
            end
        end

        // fmul rd=5, then a dependent op held valid: accepted the cycle after writeback.
        step(1, 7'b0001000, 3'd0, 1, 2, 5, 0);
        done = 0; acc_k = 0;
        for (int k = 1; k <= 8; k++) begin
            step(!done, 7'b0000000, 3'd0, 5, 6, 12, 0);
            if (!done && bus.instr_ready) begin acc_k = k; done = 1; end
        end
        check("raw_accept_cycle", acc_k, 5);
        idle(4);

        // feq rd=0 then fadd reading x0-free operands: accepted in the WB cycle.
        step(1, 7'b1010000, 3'd2, 1, 2, 0, 0);
        step(1, 7'b0000000, 3'd0, 0, 4, 7, 0);
        check("b2b_wb_valid", bus.wb_valid, 1);
        check("b2b_wb_ireg_ffr", {bus.wb_ireg, bus.wb_from_float_result}, 2'b11);
        check("b2b_ready", bus.instr_ready, 1);
        idle(1);
        check("b2b_issue", bus.issue_start, 1);
        idle(4);

        // fcvt.s.w flushed in EXEC: never writes back.
        step(1, 7'b1101000, 3'd0, 1, 2, 6, 0);
        step(0, 7'd0, 3'd0, 0, 0, 0, 1);
        wbn = 0;
        for (int k = 0; k < 4; k++) begin
            idle(1);
            if (bus.wb_valid) wbn++;
        end
        check("flush_no_wb", wbn, 0);

        // Reset in the middle of an fmul.
        step(1, 7'b0001000, 3'd0, 1, 2, 9, 0);
        idle(1);
        @(negedge clk);
        bus.instr_valid = 0;
        #2 rst = 1;
        #1 check_reset_outputs("midrst");
        @(negedge clk);
        rst = 0;
        m_in = 0; m_ill_at = -1;
        wbn = 0;
        for (int k = 0; k < 5; k++) begin
            idle(1);
            if (bus.wb_valid) wbn++;
        end
        check("midrst_no_wb", wbn, 0);

        // Randomized traffic with small register range to provoke hazards.
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 9) < 6, f7s[$urandom_range(0, 9)], 3'($urandom_range(0, 2)),
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                 $urandom_range(0, 19) == 0);
        end
        idle(6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
